// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operands are captured at issue; HI/LO are written only when the op commits.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | accepting issues; MTHI/MTLO complete here in one edge
  // RUN   | MULT/DIV in flight, down-counter running to terminal count
  typedef enum logic {IDLE, RUN} state_t;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi_d, lo_d;
  logic          done_d;
  logic          load_ops;

  // op_q[1] selects divide, op_q[0] selects unsigned
  logic [63:0] ext_a, ext_b, product;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;

  assign ext_a   = {{32{a_q[31] & ~op_q[0]}}, a_q};
  assign ext_b   = {{32{b_q[31] & ~op_q[0]}}, b_q};
  assign product = ext_a * ext_b;

  // Divide on magnitudes so the most-negative / -1 case wraps cleanly
  assign neg_a = ~op_q[0] & a_q[31];
  assign neg_b = ~op_q[0] & b_q[31];
  assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;
  assign div_b = (b_q == 32'd0) ? 32'd1 : mag_b;
  assign q_mag = mag_a / div_b;
  assign r_mag = mag_a % div_b;
  assign quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  assign busy = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    load_ops = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            state_d  = RUN;
            load_ops = 1'b1;
            cnt_d    = op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          end else if (op == 3'b100) begin
            hi_d = a;
          end else if (op == 3'b101) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!op_q[1]) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi      <= hi_d;
      lo      <= lo_d;
      done    <= done_d;
      if (load_ops) begin
        op_q <= op[1:0];
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi, m_lo;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101,
                         OP_NOP = 3'b110;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_hi", hi, mon_e[63:32]);
        chk("commit_lo", lo, mon_e[31:0]);
      end
    end
  end

  // Issue a multi-cycle op and count its busy cycles; ends at the negedge of the done cycle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int n);
    int cnt = 0;
    exp_q.push_back({eh, el});
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111; a = ~x; b = ~y;
    @(negedge clk);
    chk({name, "_hold_hi"}, hi, m_hi);
    chk({name, "_hold_lo"}, lo, m_lo);
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 32'(cnt), 32'(n));
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic mt(input string name, input logic [2:0] o, input logic [31:0] x);
    op = o; a = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111; a = 32'd0;
    if (o == OP_MTHI) m_hi = x;
    if (o == OP_MTLO) m_lo = x;
    @(negedge clk);
    chk({name, "_hi"}, hi, m_hi);
    chk({name, "_lo"}, lo, m_lo);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);

    run_op("mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op("multu",      OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
    run_op("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    run_op("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("divu",       OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10);
    run_op("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
    run_op("div_negdiv", OP_DIV,   32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 10);

    mt("mthi", OP_MTHI, 32'h1234);
    mt("mtlo", OP_MTLO, 32'h5678);
    run_op("div_by0",  OP_DIV,  32'd9, 32'd0, 32'h1234, 32'h5678, 10);
    run_op("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'h1234, 32'h5678, 10);
    mt("nop", OP_NOP, 32'hFFFF);

    // Starts presented while busy must be dropped
    exp_q.push_back({32'd0, 32'd12});
    op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    op = OP_MTLO; a = 32'hDEAD; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    op = OP_MULT; a = 32'd5; b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("ignored_tail_busy", 32'(cnt), 32'd1);
    chk("ignored_lo", lo, 32'd12);
    m_hi = 32'd0; m_lo = 32'd12;
    run_op("mult_after_done", OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25, 5);

    // A start on the commit edge is rejected
    exp_q.push_back({32'd0, 32'd6});
    op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 op = OP_MTHI; a = 32'hBEEF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("commit_edge_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("commit_edge_hi", hi, 32'd0);
    chk("commit_edge_lo", lo, 32'd6);

    // Reset during a divide discards it
    op = OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreset_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("midreset_idle", {31'd0, busy}, 32'd0);
    chk("midreset_lo_after", lo, 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the CPU datapath. It sits beside the ALU, downstream of the register file read ports (operands are rs/rt values), and upstream of the register write-data mux, which consumes its HI/LO outputs for mfhi/mflo. It owns the architectural HI and LO registers and exposes a busy flag that the controller uses to stall dependent instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears state)
- start  in  1  issue strobe, sampled each rising edge
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- a  in  32  operand A (rs value), sampled with start
- b  in  32  operand B (rt value), sampled with start
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO just committed by MULT/DIV
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

## Operation
- States: IDLE, RUN. Reset → IDLE, busy=0, done=0, hi=0, lo=0, counter=0, pending result discarded.
- Issue accepted only when start=1 and busy=0 at a rising edge. Start while busy=1 is ignored entirely (including MTHI/MTLO). The controller must stall and re-present.
- MTHI: hi←a at the accepting edge; MTLO: lo←a. Stays IDLE, busy stays 0, no done pulse.
- MULT: signed 32×32→64, {hi,lo}=product. MULTU: unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend a. 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0, DIV or DIVU): timing identical to a normal divide, but hi/lo are left unchanged at commit. done still pulses.
- Result is computed from operands latched at the accepting edge into shadow registers. Later changes on a/b/op have no effect. hi/lo keep their old values until commit.
- RUN: a down-counter is loaded with the latency. At commit, hi/lo are written from the shadow registers and the unit returns to IDLE.
- Accepted op 110/111: no state change.

## Timing
- Accepting edge E0 for MULT/MULTU/DIV/DIVU with latency N: busy=1 from just after E0 through just after E(N-1), i.e. exactly N cycles.
- At edge EN: hi/lo commit, busy→0, done→1 for exactly one cycle (cleared at EN+1).
- Back-to-back: a start at EN is rejected (busy was 1 before EN). The earliest next accept is EN+1, i.e. one idle cycle minimum between multi-cycle ops.
- MTHI/MTLO: hi/lo visible the cycle after the accepting edge. Back-to-back MTHI/MTLO is allowed every cycle.
- Reset low at any edge overrides everything, including mid-RUN and a commit edge. The result is discarded and the outputs return to their reset values the next cycle.
- hi/lo/busy/done are registered outputs with no combinational path from inputs.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release → hi=0, lo=0, busy=0, done=0.
- MULT a=0xFFFFFFFE (−2), b=3 at E0 → busy=1 for 5 cycles, hi/lo unchanged until E5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse in the cycle after E5. Repeat as MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: MTHI 0x1234 and MTLO 0x5678 (1 cycle each), then DIV a=9, b=0 → busy 10 cycles, done pulses, hi=0x1234, lo=0x5678.
- Start during busy: issue MULT, then assert MTLO a=0xDEAD and a second MULT during busy cycles 2–5 → both ignored. lo equals the first product. A MULT issued at the cycle after done is accepted.
- Reset mid-op: DIV issued, reset=0 at busy cycle 4 → next cycle busy=0, hi=lo=0, no done pulse ever appears for that DIV.
